// File: rtl/alu_4bit_if.sv
// Operand/select and result/flag bundle for the registered 4-bit ALU.
// The master drives operands and select; the ALU (slave) returns result and flags.
interface alu_4bit_if;
  logic [3:0] A;
  logic [3:0] B;
  logic [1:0] select;
  logic [3:0] out;
  logic       zero;
  logic       carry;
  logic       sign;
  logic       parity;
  logic       overflow;

  modport master (
    output A, B, select,
    input  out, zero, carry, sign, parity, overflow
  );

  modport slave (
    input  A, B, select,
    output out, zero, carry, sign, parity, overflow
  );
endinterface

// File: rtl/alu_4bit.sv
// Single-cycle registered 4-bit ALU (add, sub, AND, OR) with zero, carry/borrow,
// sign, parity and signed-overflow flags; all flags derive from the current result.
module alu_4bit (
  input  logic       clk,
  input  logic       rst,
  alu_4bit_if.slave  bus
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  function automatic logic parity4(input logic [3:0] v);
    return ^v;
  endfunction

  logic [4:0] inter_s;
  logic [3:0] result_s;
  logic       overflow_s;

  logic [3:0] out_r;
  logic       zero_r;
  logic       carry_r;
  logic       sign_r;
  logic       parity_r;
  logic       overflow_r;

  assign result_s = inter_s[3:0];

  // 5-bit intermediate; bit 4 is carry-out on add and borrow on subtract
  always_comb begin
    inter_s = 5'b0_0000;
    case (bus.select)
      OP_ADD:  inter_s = {1'b0, bus.A} + {1'b0, bus.B};
      OP_SUB:  inter_s = {1'b0, bus.A} - {1'b0, bus.B};
      OP_AND:  inter_s = {1'b0, bus.A & bus.B};
      OP_OR:   inter_s = {1'b0, bus.A | bus.B};
      default: inter_s = 5'b0_0000;
    endcase
  end

  // Signed overflow: operand signs vs. result sign, only for arithmetic ops
  always_comb begin
    overflow_s = 1'b0;
    case (bus.select)
      OP_ADD:  overflow_s = (bus.A[3] == bus.B[3]) && (result_s[3] != bus.A[3]);
      OP_SUB:  overflow_s = (bus.A[3] != bus.B[3]) && (result_s[3] != bus.A[3]);
      OP_AND:  overflow_s = 1'b0;
      OP_OR:   overflow_s = 1'b0;
      default: overflow_s = 1'b0;
    endcase
  end

  // Output registers; reset clears everything including the zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r      <= 4'b0000;
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      sign_r     <= 1'b0;
      parity_r   <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      out_r      <= result_s;
      zero_r     <= (result_s == 4'b0000);
      carry_r    <= inter_s[4];
      sign_r     <= result_s[3];
      parity_r   <= parity4(result_s);
      overflow_r <= overflow_s;
    end
  end

  assign bus.out      = out_r;
  assign bus.zero     = zero_r;
  assign bus.carry    = carry_r;
  assign bus.sign     = sign_r;
  assign bus.parity   = parity_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_alu_4bit.sv
// Directed and random self-checking bench for alu_4bit.
// Observed vector packing: {out[3:0], zero, carry, sign, parity, overflow}.
module tb_alu_4bit;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_4bit_if bus ();

  alu_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] observed();
    return {bus.out, bus.zero, bus.carry, bus.sign, bus.parity, bus.overflow};
  endfunction

  // Independent reference: integer arithmetic with signed range check for overflow
  function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic [1:0] sel);
    int ua, ub, sa, sb, ur, sr;
    logic [3:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c  = 1'b0;
    v  = 1'b0;
    ur = 0;
    case (sel)
      2'b00: begin
        ur = ua + ub;
        c  = (ur > 15);
        sr = sa + sb;
        v  = (sr > 7) || (sr < -8);
      end
      2'b01: begin
        ur = ua - ub + 16;
        c  = (ua < ub);
        sr = sa - sb;
        v  = (sr > 7) || (sr < -8);
      end
      2'b10: ur = int'(a & b);
      default: ur = int'(a | b);
    endcase
    r = ur[3:0];
    return {r, (r == 4'd0), c, r[3], ^r, v};
  endfunction

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    bus.A      = a;
    bus.B      = b;
    bus.select = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [1:0] rs;
    logic [8:0] held;

    rst = 1'b1;
    apply(4'b1111, 4'b1111, 2'b00);
    check_val("reset_c1", observed(), 9'b0000_00000);
    apply(4'b1111, 4'b1111, 2'b00);
    check_val("reset_c2", observed(), 9'b0000_00000);
    rst = 1'b0;

    apply(4'b0111, 4'b0001, 2'b00);
    check_val("add_ovf", observed(), 9'b1000_00111);
    apply(4'b1111, 4'b0001, 2'b00);
    check_val("add_wrap", observed(), 9'b0000_11000);
    apply(4'b0011, 4'b0101, 2'b01);
    check_val("sub_borrow", observed(), 9'b1110_01110);
    apply(4'b1000, 4'b0001, 2'b01);
    check_val("sub_ovf", observed(), 9'b0111_00011);
    apply(4'b1100, 4'b1010, 2'b10);
    check_val("and", observed(), 9'b1000_00110);
    apply(4'b1100, 4'b1010, 2'b11);
    check_val("or", observed(), 9'b1110_00110);
    apply(4'b0101, 4'b0101, 2'b01);
    check_val("sub_equal", observed(), 9'b0000_10000);
    apply(4'b0000, 4'b0001, 2'b01);
    check_val("sub_0_minus_1", observed(), 9'b1111_01100);
    apply(4'b1000, 4'b1000, 2'b00);
    check_val("add_neg_ovf", observed(), 9'b0000_11001);

    // Inputs changing between edges must not disturb the registered outputs
    held = observed();
    bus.A      = 4'b0110;
    bus.B      = 4'b0011;
    bus.select = 2'b11;
    #3;
    check_val("hold_between_edges", observed(), 9'b0000_11001);
    @(posedge clk);
    #1;
    check_val("after_hold_edge", observed(), 9'b0111_00010);
    if (held == observed()) check_val("hold_changed", observed(), ~held);

    // Reset mid-stream: zero flag must stay 0 even though out is 0000
    rst = 1'b1;
    apply(4'b0111, 4'b0001, 2'b00);
    check_val("reset_mid", observed(), 9'b0000_00000);
    rst = 1'b0;
    apply(4'b0010, 4'b0011, 2'b00);
    check_val("first_after_reset", observed(), 9'b0101_00000);

    for (int i = 0; i < 100; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 2'($urandom_range(0, 3));
      apply(ra, rb, rs);
      check_val("random", observed(), model(ra, rb, rs));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
